alu_seq: RTL and testbench

Parametrised, handshaked integer ALU for the RISC-V datapath. It replaces the single-cycle combinational ALU and keeps that ALU's 4-bit opcode encoding for add, sub, and and or. It adds logic, shift and compare ops, plus iterative multiply and divide/remainder. It sits between decode/register-read and writeback, and stalls the issuing stage through a valid/ready handshake.

---
 rtl/alu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked integer ALU: single-cycle logic/arith/shift/compare plus
// iterative shift-add multiply and restoring divide sharing one 2*WIDTH register.
module alu_seq #(
    parameter int WIDTH = 64  // power of two, >= 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic [WIDTH:0]     final_s;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    // Returns {carry, value} for the single-cycle ops; reserved codes give zero.
    function automatic logic [WIDTH:0] single_op(input logic [3:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        logic [WIDTH:0] r;
        sh = b[SHW-1:0];
        case (op)
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_XOR:  r = {1'b0, a ^ b};
            OP_SLL:  r = {1'b0, a << sh};
            OP_SRL:  r = {1'b0, a >> sh};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_SRA:  r = {1'b0, $signed(a) >>> sh};
            OP_SLT:  r = {{WIDTH{1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{WIDTH{1'b0}}, (a < b)};
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    // One multiply step (shift-add) and one restoring-divide step on the shared accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, x_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, y_q};
    end

    // Value written into the result registers when a completed op lands in DONE.
    always_comb begin
        case (op_q)
            OP_MUL:   final_s = {1'b0, acc_q[WIDTH-1:0]};
            OP_MULHU: final_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            OP_DIVU:  final_s = {1'b0, acc_q[WIDTH-1:0]};
            OP_REMU:  final_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            default:  final_s = single_op(op_q, x_q, y_q);
        endcase
    end

    // Next-state and datapath control for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        cout_d      = cout_q;
        zero_d      = zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = alu_op;
                    x_d   = x;
                    y_d   = y;
                    cnt_d = {CW{1'b0}};
                    if (is_multi(alu_op)) begin
                        // Multiplier (y) or dividend (x) starts in the low half.
                        if (alu_op[3:2] == 2'b10) begin
                            acc_d = {{WIDTH{1'b0}}, y};
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, x};
                        end
                        state_d = S_CALC;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (op_q[3:2] == 2'b10) begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end else if (!div_diff_s[WIDTH]) begin
                    acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (!out_valid_q) begin
                    result_d    = final_s[WIDTH-1:0];
                    cout_d      = final_s[WIDTH];
                    zero_d      = (final_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 4'b0000;
            x_q         <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            cnt_q       <= {CW{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 64) with hand-computed expectations.
module tb_alu_seq;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic [3:0]    alu_op = 4'b0000;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          cout;
    logic          zero;
    logic          busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Present one op for a single accept edge, then wait for out_valid.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt);
        alu_op   = op;
        x        = a;
        y        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 200) check("timeout", 64'(lat), 64'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic op_check(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp_r,
                            input logic exp_c, input logic exp_z, input int exp_lat);
        int lat;
        int bc;
        run_op(op, a, b, lat, bc);
        check({tag, "_res"},  result, exp_r);
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, exp_c});
        check({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_z});
        check({tag, "_lat"},  64'(lat), 64'(exp_lat));
        handshake(tag);
    endtask

    initial begin
        int lat;
        int bc;
        logic [W-1:0] held_r;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_ovalid",   {63'd0, out_valid}, 64'd0);
        check("rst_busy",     {63'd0, busy}, 64'd0);
        check("rst_result",   result, 64'd0);
        check("rst_cout",     {63'd0, cout}, 64'd0);
        check("rst_zero",     {63'd0, zero}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op_check("add_ovf", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1, 1);
        op_check("sub",     4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1);
        op_check("sub_nb",  4'b0110, 64'd9, 64'd4, 64'd5, 1'b0, 1'b0, 1);
        op_check("and",     4'b0000, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_FF00, 64'h00F0_0000_00FF_1200, 1'b0, 1'b0, 1);
        op_check("or",      4'b0001, 64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1);
        op_check("xor",     4'b0011, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_0000_FFFF_0000, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b0, 1);
        op_check("sll",     4'b0100, 64'h1, 64'h7F, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1);
        op_check("srl",     4'b0101, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 1);
        op_check("sra",     4'b0111, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b0, 1);
        op_check("slt",     4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1'b0, 1);
        op_check("sltu",    4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1, 1);
        op_check("rsvd",    4'b1110, 64'd7, 64'd9, 64'd0, 1'b0, 1'b1, 1);

        run_op(4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, lat, bc);
        check("mul_res",  result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mul_cout", {63'd0, cout}, 64'd0);
        check("mul_lat",  64'(lat), 64'd65);
        check("mul_busy", 64'(bc), 64'd64);
        handshake("mul");
        op_check("mulhu", 4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0, 1'b0, 65);
        op_check("mul2",  4'b1010, 64'd123456789, 64'd1000, 64'd123456789000, 1'b0, 1'b0, 65);
        op_check("divu",  4'b1100, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 65);
        op_check("remu",  4'b1101, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0, 65);
        op_check("divu0", 4'b1100, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65);
        op_check("remu0", 4'b1101, 64'h1234, 64'd0, 64'h1234, 1'b0, 1'b0, 65);

        // Backpressure: hold the result while a new request is waved at the block.
        run_op(4'b0110, 64'd3, 64'd5, lat, bc);
        held_r = result;
        check("bp_first", held_r, 64'hFFFF_FFFF_FFFF_FFFE);
        alu_op   = 4'b0010;
        x        = 64'd40;
        y        = 64'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_res",      result, held_r);
            check("bp_cout",     {63'd0, cout}, 64'd1);
            check("bp_zero",     {63'd0, zero}, 64'd0);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_ovalid",   {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        handshake("bp");
        check("bp_idle", {63'd0, in_ready}, 64'd1);
        check("bp_kept", result, held_r);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_accept", {63'd0, out_valid}, 64'd0);

        // Reset in the middle of a multiply.
        alu_op   = 4'b1010;
        x        = 64'd5;
        y        = 64'd6;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_ovalid",   {63'd0, out_valid}, 64'd0);
        check("mrst_busy",     {63'd0, busy}, 64'd0);
        check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mrst_result",   result, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        op_check("post_add", 4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
